hazard_scheduler: RTL and testbench

//  Pipeline sequencing controller for the decode stage. Tracks the instruction issued into EX,

---
 rtl/hazard_scheduler_if.sv | 32 +++
 rtl/hazard_scheduler.sv | 119 +++++++++++
 tb/tb_hazard_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scheduler_if.sv
// ID-stage <-> hazard scheduler signal bundle.
// master = decode-stage side, slave = scheduler.
interface hazard_scheduler_if;
  logic        id_valid;
  logic [4:0]  id_reg_rs;
  logic [4:0]  id_reg_rt;
  logic [4:0]  id_reg_dest;
  logic        id_wb_en;
  logic        id_mem_r;
  logic        id_is_branch;
  logic        branch_taken;
  logic        jump_taken;
  logic        terminate;
  logic        stall;
  logic        pc_hold;
  logic        flush_if;
  logic        halted;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  modport master (
    output id_valid, id_reg_rs, id_reg_rt, id_reg_dest, id_wb_en, id_mem_r,
           id_is_branch, branch_taken, jump_taken, terminate,
    input  stall, pc_hold, flush_if, halted, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_reg_rs, id_reg_rt, id_reg_dest, id_wb_en, id_mem_r,
           id_is_branch, branch_taken, jump_taken, terminate,
    output stall, pc_hold, flush_if, halted, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// Decode-stage hazard scheduler: load-use / branch-operand bubbles, taken-branch flush, terminate drain.
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating stall/flush performance counters).
module hazard_scheduler #(
  parameter int LOAD_STALL   = 1,
  parameter int BR_ALU_STALL = 1,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  hazard_scheduler_if.slave bus
);
  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALT} state_t;

  localparam logic [7:0] LOAD_N    = 8'(LOAD_STALL);
  localparam logic [7:0] LOAD_BR_N = 8'(LOAD_STALL + 1);
  localparam logic [7:0] BR_N      = 8'(BR_ALU_STALL);
  localparam logic [7:0] DRAIN_N   = 8'(DRAIN_CYCLES - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic        ex_valid_reg;
  logic        ex_load_reg;
  logic [4:0]  ex_dest_reg;
  logic        halted_reg;

  logic        hazard;
  logic [7:0]  need;
  logic        stall_now;
  logic        flush_now;

  always_comb begin
    hazard = bus.id_valid && ex_valid_reg &&
             ((bus.id_reg_rs != 5'd0 && bus.id_reg_rs == ex_dest_reg) ||
              (bus.id_reg_rt != 5'd0 && bus.id_reg_rt == ex_dest_reg));
    need = 8'd0;
    if (hazard) begin
      if (ex_load_reg && bus.id_is_branch) need = LOAD_BR_N;
      else if (ex_load_reg)                need = LOAD_N;
      else if (bus.id_is_branch)           need = BR_N;
    end
    // Gated by rst so every output drops the instant reset is asserted.
    stall_now = rst && ((state_reg != RUN) || (need != 8'd0));
    flush_now = rst && (state_reg == RUN) && !stall_now && bus.id_valid &&
                (bus.branch_taken || bus.jump_taken) && !bus.terminate;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= RUN;
      cnt_reg      <= 8'd0;
      ex_valid_reg <= 1'b0;
      ex_load_reg  <= 1'b0;
      ex_dest_reg  <= 5'd0;
      halted_reg   <= 1'b0;
    end else begin
      // A stalled instruction never enters EX, so a producer can only trigger one stall episode.
      ex_valid_reg <= bus.id_valid && bus.id_wb_en && (bus.id_reg_dest != 5'd0) && !stall_now;
      ex_load_reg  <= bus.id_mem_r;
      ex_dest_reg  <= bus.id_reg_dest;
      case (state_reg)
        RUN: begin
          if (need != 8'd0) begin
            cnt_reg <= need - 8'd1;
            if (need > 8'd1) state_reg <= STALL;
          end else if (bus.terminate) begin
            cnt_reg   <= DRAIN_N;
            state_reg <= DRAIN;
          end
        end
        STALL: begin
          // The RUN cycle was the first bubble; leave once the count decrements to zero.
          if (cnt_reg <= 8'd1) begin
            cnt_reg   <= 8'd0;
            state_reg <= RUN;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        DRAIN: begin
          if (cnt_reg == 8'd0) begin
            state_reg  <= HALT;
            halted_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 8'd1;
          end
        end
        default: halted_reg <= 1'b1;
      endcase
    end
  end

  assign bus.stall    = stall_now;
  assign bus.pc_hold  = stall_now;
  assign bus.flush_if = flush_now;
  assign bus.halted   = halted_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_count_reg;
  logic [15:0] flush_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_reg <= 16'h0;
      flush_count_reg <= 16'h0;
    end else begin
      if (stall_now && (state_reg == RUN || state_reg == STALL) && stall_count_reg != 16'hffff)
        stall_count_reg <= stall_count_reg + 16'd1;
      if (flush_now && flush_count_reg != 16'hffff)
        flush_count_reg <= flush_count_reg + 16'd1;
    end
  end

  assign bus.stall_count = stall_count_reg;
  assign bus.flush_count = flush_count_reg;
`else
  assign bus.stall_count = 16'h0;
  assign bus.flush_count = 16'h0;
`endif
endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench for hazard_scheduler: directed scenarios plus randomized traffic vs. a cycle model.
// Build with +define+HAZARD_PERF_CNT_EN to exercise the counters.
module tb_hazard_scheduler;
  localparam int LS  = 1;
  localparam int BRS = 1;
  localparam int DC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_scheduler_if bus();

  hazard_scheduler #(.LOAD_STALL(LS), .BR_ALU_STALL(BRS), .DRAIN_CYCLES(DC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic       v;
    logic [4:0] rs, rt, dest;
    logic       wb, ld, br, bt, jt, term;
    logic [3:0] want;   // {stall, pc_hold, flush_if, halted}
  } step_t;

  // Reference model: last instruction that issued, outstanding bubbles/drain cycles, halt flag.
  int         m_bubbles, m_drain, m_stall_cnt, m_flush_cnt, m_raw_stalls;
  logic       m_halted, m_last_v, m_last_load;
  logic [4:0] m_last_dest;
  int         nb, nd;
  logic       nh, nlv, nld, inc_stall, inc_flush;
  logic [4:0] ndest;
  logic       exp_stall, exp_flush, exp_halted;

  function automatic step_t st(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] dest, input logic wb, input logic ld,
                               input logic br, input logic bt, input logic jt,
                               input logic term, input logic [3:0] want);
    step_t s;
    s = '{v, rs, rt, dest, wb, ld, br, bt, jt, term, want};
    return s;
  endfunction

  function automatic logic [3:0] outs();
    return {bus.stall, bus.pc_hold, bus.flush_if, bus.halted};
  endfunction

  function automatic logic [31:0] exp_counts();
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] s, f;
    s = m_stall_cnt;
    f = m_flush_cnt;
    return {s[15:0], f[15:0]};
`else
    return 32'h0;
`endif
  endfunction

  task automatic model_reset();
    m_bubbles = 0; m_drain = 0; m_halted = 0; m_last_v = 0; m_last_load = 0;
    m_last_dest = 0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  task automatic model_predict();
    int   n;
    logic hit;
    nb = m_bubbles; nd = m_drain; nh = m_halted;
    inc_stall = 0; exp_flush = 0; exp_stall = 0; exp_halted = m_halted;
    if (m_halted) begin
      exp_stall = 1;
    end else if (m_drain > 0) begin
      exp_stall = 1;
      nd = m_drain - 1;
      if (nd == 0) nh = 1;
    end else if (m_bubbles > 0) begin
      exp_stall = 1; nb = m_bubbles - 1; inc_stall = 1;
    end else begin
      hit = m_last_v && bus.id_valid &&
            ((bus.id_reg_rs != 0 && bus.id_reg_rs == m_last_dest) ||
             (bus.id_reg_rt != 0 && bus.id_reg_rt == m_last_dest));
      if (!hit)             n = 0;
      else if (m_last_load) n = bus.id_is_branch ? LS + 1 : LS;
      else                  n = bus.id_is_branch ? BRS : 0;
      if (n > 0) begin
        exp_stall = 1; nb = n - 1; inc_stall = 1;
      end else if (bus.terminate) begin
        nd = DC;
      end else begin
        exp_flush = bus.id_valid && (bus.branch_taken || bus.jump_taken);
      end
    end
    inc_flush = exp_flush;
    nlv   = bus.id_valid && bus.id_wb_en && bus.id_reg_dest != 0 && !exp_stall;
    nld   = bus.id_mem_r;
    ndest = bus.id_reg_dest;
  endtask

  task automatic drive(input step_t s);
    bus.id_valid = s.v; bus.id_reg_rs = s.rs; bus.id_reg_rt = s.rt; bus.id_reg_dest = s.dest;
    bus.id_wb_en = s.wb; bus.id_mem_r = s.ld; bus.id_is_branch = s.br;
    bus.branch_taken = s.bt; bus.jump_taken = s.jt; bus.terminate = s.term;
    #1;
    model_predict();
  endtask

  task automatic tick();
    m_bubbles = nb; m_drain = nd; m_halted = nh;
    m_last_v = nlv; m_last_load = nld; m_last_dest = ndest;
    if (inc_stall && m_stall_cnt < 65535) m_stall_cnt++;
    if (inc_flush && m_flush_cnt < 65535) m_flush_cnt++;
    if (inc_stall) m_raw_stalls++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    bus.id_valid = 0; bus.id_reg_rs = 0; bus.id_reg_rt = 0; bus.id_reg_dest = 0;
    bus.id_wb_en = 0; bus.id_mem_r = 0; bus.id_is_branch = 0;
    bus.branch_taken = 0; bus.jump_taken = 0; bus.terminate = 0;
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    set_idle();
    #2 rst = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_reset();
    set_idle();
    #1;
    vectors++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL reset_outs: got %b exp 0000", outs()); end
    else $display("reset outs=%b", outs());
    vectors++;
    if ({bus.stall_count, bus.flush_count} !== 32'h0) begin
      errors++; $display("FAIL reset_counts: got %h exp 00000000", {bus.stall_count, bus.flush_count});
    end
    release_reset();
  endtask

  task automatic test_load_use();
    step_t q[$];
    q = {st(1, 0, 0, 2, 1, 1, 0, 0, 0, 0, 4'b0000),   // lw r2
         st(1, 2, 4, 3, 1, 0, 0, 0, 0, 0, 4'b1100),   // add r3,r2,r4 -> 1 bubble
         st(1, 2, 4, 3, 1, 0, 0, 0, 0, 0, 4'b0000),   // add issues
         st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000)};
    foreach (q[i]) begin
      drive(q[i]); vectors++;
      if (outs() !== q[i].want) begin errors++; $display("FAIL load_use[%0d]: got %b exp %b", i, outs(), q[i].want); end
      else $display("load_use[%0d] outs=%b", i, outs());
      tick();
    end
  endtask

  task automatic test_branch_hazard();
    step_t q[$];
    q = {st(1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 4'b0000),   // add r5
         st(1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 4'b1100),   // beq r5,r6 taken: 1 bubble, no flush
         st(1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 4'b0010),   // re-evaluated: flush
         st(1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 4'b0000),   // lw r5
         st(1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 4'b1100),   // beq r5,r6: 2 bubbles
         st(1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 4'b1100),
         st(1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 4'b0010),
         st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000)};
    foreach (q[i]) begin
      drive(q[i]); vectors++;
      if (outs() !== q[i].want) begin errors++; $display("FAIL branch_hazard[%0d]: got %b exp %b", i, outs(), q[i].want); end
      else $display("branch_hazard[%0d] outs=%b", i, outs());
      tick();
    end
  endtask

  task automatic test_no_stall();
    step_t q[$];
    q = {st(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 4'b0000),   // lw r0
         st(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0000),   // add r1,r0,r0
         st(1, 2, 3, 7, 1, 0, 0, 0, 0, 0, 4'b0000),   // add r7
         st(1, 7, 7, 8, 1, 0, 0, 0, 0, 0, 4'b0000)};  // sub r8,r7,r7 forwarded
    foreach (q[i]) begin
      drive(q[i]); vectors++;
      if (outs() !== q[i].want) begin errors++; $display("FAIL no_stall[%0d]: got %b exp %b", i, outs(), q[i].want); end
      else $display("no_stall[%0d] outs=%b", i, outs());
      tick();
    end
  endtask

  task automatic test_jump_flush();
    step_t q[$];
    assert_reset();
    release_reset();
    q = {st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0010),
         st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000),   // bubble in ID: no flush
         st(1, 3, 0, 4, 1, 0, 0, 0, 0, 0, 4'b0000)};
    foreach (q[i]) begin
      drive(q[i]); vectors++;
      if (outs() !== q[i].want) begin errors++; $display("FAIL jump_flush[%0d]: got %b exp %b", i, outs(), q[i].want); end
      else $display("jump_flush[%0d] outs=%b", i, outs());
      tick();
    end
    vectors++;
    if ({bus.stall_count, bus.flush_count} !== exp_counts()) begin
      errors++; $display("FAIL jump_counts: got %h exp %h", {bus.stall_count, bus.flush_count}, exp_counts());
    end
  endtask

  task automatic test_terminate();
    step_t q[$];
    q = {st(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0000)};  // terminate + jump: terminate wins
    for (int i = 0; i < DC; i++) q.push_back(st(1, 1, 2, 3, 1, 0, 0, 0, 1, 0, 4'b1100));
    for (int i = 0; i < 3; i++)  q.push_back(st(1, 1, 2, 3, 1, 0, 0, 0, 1, 1, 4'b1101));
    foreach (q[i]) begin
      drive(q[i]); vectors++;
      if (outs() !== q[i].want) begin errors++; $display("FAIL terminate[%0d]: got %b exp %b", i, outs(), q[i].want); end
      else $display("terminate[%0d] outs=%b", i, outs());
      tick();
    end
  endtask

  task automatic test_reset_mid();
    assert_reset();
    release_reset();
    drive(st(1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 4'b0000)); tick();
    drive(st(1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 4'b1100)); tick();
    drive(st(1, 5, 6, 0, 0, 0, 1, 1, 0, 0, 4'b1100));
    vectors++;
    if (outs() !== 4'b1100) begin errors++; $display("FAIL mid_stall_pre: got %b exp 1100", outs()); end
    assert_reset();
    vectors++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL mid_stall_rst: got %b exp 0000", outs()); end
    else $display("reset_mid stall outs=%b", outs());
    vectors++;
    if ({bus.stall_count, bus.flush_count} !== 32'h0) begin
      errors++; $display("FAIL mid_stall_counts: got %h exp 00000000", {bus.stall_count, bus.flush_count});
    end
    release_reset();
    drive(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0010));
    vectors++;
    if (outs() !== 4'b0010) begin errors++; $display("FAIL run_after_rst: got %b exp 0010", outs()); end
    else $display("reset_mid run outs=%b", outs());
    tick();
    drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000));
    for (int i = 0; i <= DC; i++) tick();
    vectors++;
    if (outs() !== 4'b1101) begin errors++; $display("FAIL halt_pre: got %b exp 1101", outs()); end
    assert_reset();
    vectors++;
    if (outs() !== 4'b0000) begin errors++; $display("FAIL halt_rst: got %b exp 0000", outs()); end
    else $display("reset_mid halt outs=%b", outs());
    release_reset();
  endtask

  task automatic test_random();
    step_t s;
    logic [35:0] got, want;
    for (int c = 0; c < 1200; c++) begin
      if (m_halted && $urandom_range(0, 3) == 0) begin
        assert_reset();
        release_reset();
      end
      s.v    = ($urandom_range(0, 9) != 0);
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.dest = 5'($urandom_range(0, 3));
      s.wb   = ($urandom_range(0, 9) < 7);
      s.ld   = ($urandom_range(0, 9) < 4);
      s.br   = ($urandom_range(0, 3) == 0);
      s.bt   = s.br && $urandom_range(0, 1) == 1;
      s.jt   = !s.br && $urandom_range(0, 9) == 0;
      s.term = ($urandom_range(0, 149) == 0);
      s.want = 4'b0000;
      drive(s);
      want = {exp_stall, exp_stall, exp_flush, exp_halted, exp_counts()};
      got  = {outs(), bus.stall_count, bus.flush_count};
      vectors++;
      if (got !== want) begin errors++; $display("FAIL random[%0d]: got %h exp %h", c, got, want); end
      else $display("random[%0d] v=%b rs=%0d rt=%0d d=%0d wb=%b ld=%b br=%b bt=%b jt=%b t=%b outs=%b",
                    c, s.v, s.rs, s.rt, s.dest, s.wb, s.ld, s.br, s.bt, s.jt, s.term, outs());
      tick();
    end
  endtask

  task automatic test_counters();
    logic [15:0] want_sc;
    assert_reset();
    release_reset();
    m_raw_stalls = 0;
`ifdef HAZARD_PERF_CNT_EN
    want_sc = 16'hffff;
    while (m_raw_stalls < 65600) begin
`else
    want_sc = 16'h0;
    while (m_raw_stalls < 2000) begin
`endif
      // lw r2 <- r2 tagged as branch: every issue re-arms a load-use-branch hazard
      drive(st(1, 2, 0, 2, 1, 1, 1, 0, 0, 0, 4'b0000));
      tick();
    end
    set_idle();
    #1;
    vectors++;
    if (bus.stall_count !== want_sc) begin errors++; $display("FAIL stall_count_sat: got %h exp %h", bus.stall_count, want_sc); end
    else $display("counters stall_count=%h after %0d stalls", bus.stall_count, m_raw_stalls);
    vectors++;
    if ({bus.stall_count, bus.flush_count} !== exp_counts()) begin
      errors++; $display("FAIL counters_model: got %h exp %h", {bus.stall_count, bus.flush_count}, exp_counts());
    end
  endtask

  initial begin
    model_reset();
    m_raw_stalls = 0;
    test_reset();
    test_load_use();
    test_branch_hazard();
    test_no_stall();
    test_jump_flush();
    test_terminate();
    test_reset_mid();
    test_random();
    test_counters();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
